// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO.
// A single Add32 instance is time-shared across the operand abs passes,
// 32 shift-add / restoring-divide steps and the two sign-fix passes.
// Fixed latency: done pulses 37 cycles after the start is accepted.
// Optional feature: define MULDIV_ABORT_EN to add the abort input and
// the shadow HI/LO pair that is restored when an op is abandoned.

module Add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  // 32-bit add with carry in and carry out
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
  end

endmodule

module muldiv_seq #(
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef MULDIV_ABORT_EN
  input  logic        abort,
`endif
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  typedef enum logic [2:0] {
    IDLE,
    ABS_A,
    ABS_B,
    RUN,
    FIX_LO,
    FIX_HI,
    DONE
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        neg_a;
  logic        sign_diff;
  logic        carry_q;
  logic        dz_q;
  logic [4:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;

  logic        is_div;
  logic        is_signed;
  logic        div_zero;
  logic        accept;

`ifdef MULDIV_ABORT_EN
  logic [31:0] hi_sh;
  logic [31:0] lo_sh;
  logic        in_flight;
  logic        abort_hit;

  assign in_flight = (state != IDLE) && (state != DONE);
  assign abort_hit = abort && in_flight;
`endif

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];
  assign div_zero  = is_div && (b_q == 32'd0);
  assign accept    = start && ((state == IDLE) || (state == DONE));

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dz_q;

  Add32 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode plus busy/done; abort overrides any transition
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = ABS_A;
      end
      ABS_A: begin
        busy       = 1'b1;
        next_state = ABS_B;
      end
      ABS_B: begin
        busy       = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == 5'd31) next_state = FIX_LO;
      end
      FIX_LO: begin
        busy       = 1'b1;
        next_state = FIX_HI;
      end
      FIX_HI: begin
        busy       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = start ? ABS_A : IDLE;
      end
      default: next_state = IDLE;
    endcase
`ifdef MULDIV_ABORT_EN
    if (abort_hit) next_state = IDLE;
`endif
  end

  // Adder operand steering: negation is ~x + 1, subtraction is A + ~B + 1
  always_comb begin
    add_a   = 32'd0;
    add_b   = 32'd0;
    add_cin = 1'b0;
    case (state)
      ABS_A: begin
        if (is_signed && a_q[31]) begin
          add_a   = ~a_q;
          add_cin = 1'b1;
        end else begin
          add_a = a_q;
        end
      end
      ABS_B: begin
        if (is_signed && b_q[31]) begin
          add_a   = ~b_q;
          add_cin = 1'b1;
        end else begin
          add_a = b_q;
        end
      end
      RUN: begin
        if (is_div) begin
          add_a   = {hi_q[30:0], lo_q[31]};
          add_b   = ~abs_b;
          add_cin = 1'b1;
        end else begin
          add_a = hi_q;
          add_b = lo_q[0] ? abs_a : 32'd0;
        end
      end
      FIX_LO: begin
        add_a   = ~lo_q;
        add_cin = 1'b1;
      end
      FIX_HI: begin
        add_a   = ~hi_q;
        add_cin = is_div ? 1'b1 : carry_q;
      end
      default: begin
        add_a   = 32'd0;
        add_b   = 32'd0;
        add_cin = 1'b0;
      end
    endcase
  end

  // Datapath: operand latch, abs passes, iteration steps and sign fixes
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= 2'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      abs_a     <= 32'd0;
      abs_b     <= 32'd0;
      neg_a     <= 1'b0;
      sign_diff <= 1'b0;
      carry_q   <= 1'b0;
      dz_q      <= 1'b0;
      cnt       <= 5'd0;
      hi_q      <= HILO_RST;
      lo_q      <= HILO_RST;
`ifdef MULDIV_ABORT_EN
      hi_sh     <= HILO_RST;
      lo_sh     <= HILO_RST;
    end else if (abort_hit) begin
      hi_q <= hi_sh;
      lo_q <= lo_sh;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            dz_q  <= 1'b0;
`ifdef MULDIV_ABORT_EN
            hi_sh <= hi_q;
            lo_sh <= lo_q;
`endif
          end
        end
        ABS_A: begin
          abs_a     <= add_sum;
          neg_a     <= is_signed && a_q[31];
          sign_diff <= is_signed && (a_q[31] ^ b_q[31]);
          cnt       <= 5'd0;
        end
        ABS_B: begin
          abs_b <= add_sum;
          hi_q  <= 32'd0;
          lo_q  <= is_div ? abs_a : add_sum;
          cnt   <= 5'd0;
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            if (hi_q[31] || add_cout) begin
              hi_q <= add_sum;
              lo_q <= {lo_q[30:0], 1'b1};
            end else begin
              hi_q <= {hi_q[30:0], lo_q[31]};
              lo_q <= {lo_q[30:0], 1'b0};
            end
          end else begin
            hi_q <= {add_cout, add_sum[31:1]};
            lo_q <= {add_sum[0], lo_q[31:1]};
          end
        end
        FIX_LO: begin
          carry_q <= add_cout;
          if (div_zero) begin
            lo_q <= 32'hFFFF_FFFF;
          end else if (sign_diff) begin
            lo_q <= add_sum;
          end
        end
        FIX_HI: begin
          if (div_zero) begin
            hi_q <= a_q;
            dz_q <= 1'b1;
          end else if ((!is_div && sign_diff) || (is_div && neg_a)) begin
            hi_q <= add_sum;
          end
        end
        default: begin
          cnt <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: directed and random ops against a plain
// 64-bit arithmetic reference model, checked by a done-driven scoreboard.

module tb_muldiv_seq;

  localparam logic [31:0] HILO_RST = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;
`ifdef MULDIV_ABORT_EN
  logic        abort;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  logic [31:0] last_hi;
  logic [31:0] last_lo;
  logic [31:0] rx;
  logic [31:0] ry;

  muldiv_seq #(.HILO_RST(HILO_RST)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
`ifdef MULDIV_ABORT_EN
    .abort       (abort),
`endif
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock
  initial forever #5 clk = ~clk;

  // Posedge counter used to check done latency
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: straight 64-bit arithmetic on the operands
  function automatic exp_t ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        r;
    logic [63:0] up;
    longint      sx;
    longint      sy;
    longint      q;
    longint      m;
    r.dz  = 1'b0;
    r.due = 0;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    if (o[1] && (y == 32'd0)) begin
      r.lo = 32'hFFFF_FFFF;
      r.hi = x;
      r.dz = 1'b1;
    end else begin
      case (o)
        2'd0: up = {32'd0, x} * {32'd0, y};
        2'd1: up = 64'(sx * sy);
        2'd2: up = {x % y, x / y};
        default: begin
          q  = sx / sy;
          m  = sx % sy;
          up = {m[31:0], q[31:0]};
        end
      endcase
      r.hi = up[63:32];
      r.lo = up[31:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Wait for the unit to be free, launch one op, optionally score it
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
    exp_t e;
    int   g;
    g = 0;
    while (busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    checkOutput("ready_wait", 32'(busy), 32'd0);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    e     = ref_model(o, x, y);
    e.due = cyc + 37;
    if (push) sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    a     = 32'($urandom);
    b     = 32'($urandom);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL drain_timeout: got %0d pending, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("hi", hi, mon_e.hi);
        checkOutput("lo", lo, mon_e.lo);
        checkOutput("div_by_zero", 32'(div_by_zero), 32'(mon_e.dz));
        checkOutput("latency", 32'(cyc), 32'(mon_e.due));
        checkOutput("busy_in_done", 32'(busy), 32'd0);
        last_hi = mon_e.hi;
        last_lo = mon_e.lo;
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 2'd0;
    a     = 32'd0;
    b     = 32'd0;
`ifdef MULDIV_ABORT_EN
    abort = 1'b0;
`endif
    last_hi = HILO_RST;
    last_lo = HILO_RST;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_dz", 32'(div_by_zero), 32'd0);
    checkOutput("rst_hi", hi, HILO_RST);
    checkOutput("rst_lo", lo, HILO_RST);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] directed ops, issued back to back");
    applyStimulus(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(2'd1, 32'hFFFF_FFFD, 32'd5, 1'b1);
    applyStimulus(2'd2, 32'd100, 32'd7, 1'b1);
    applyStimulus(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    applyStimulus(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(2'd2, 32'h0000_1234, 32'd0, 1'b1);
    applyStimulus(2'd0, 32'd2, 32'd3, 1'b1);
    applyStimulus(2'd3, 32'hFFFF_FFF0, 32'd0, 1'b1);
    wait_drain();

    $display("[TB] start pulsed while busy");
    applyStimulus(2'd2, 32'd1000, 32'd9, 1'b1);
    repeat (3) @(negedge clk);
    op    = 2'd0;
    a     = 32'd5;
    b     = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    $display("[TB] random ops");
    for (int i = 0; i < 40; i++) begin
      rx = pick_operand();
      ry = pick_operand();
      applyStimulus(2'($urandom_range(0, 3)), rx, ry, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        wait_drain();
        repeat ($urandom_range(1, 5)) @(negedge clk);
      end
    end
    wait_drain();
    repeat (3) @(negedge clk);
    checkOutput("hold_hi", hi, last_hi);
    checkOutput("hold_lo", lo, last_lo);

    $display("[TB] reset mid-op");
    applyStimulus(2'd1, 32'h1234_5678, 32'h8765_4321, 1'b0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_hi", hi, HILO_RST);
    checkOutput("midrst_lo", lo, HILO_RST);
    last_hi = HILO_RST;
    last_lo = HILO_RST;
    repeat (45) @(negedge clk);
    checkOutput("midrst_idle", 32'(busy), 32'd0);

`ifdef MULDIV_ABORT_EN
    $display("[TB] abort mid-op");
    applyStimulus(2'd1, 32'd7, 32'hFFFF_FFF7, 1'b1);
    wait_drain();
    applyStimulus(2'd2, 32'd50, 32'd3, 1'b0);
    repeat (17) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_hi", hi, last_hi);
    checkOutput("abort_lo", lo, last_lo);
    repeat (45) @(negedge clk);
`endif

    applyStimulus(2'd0, 32'd2, 32'd3, 1'b1);
    wait_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
